// File: rtl/convert_signed_magnitude.sv
`default_nettype none
// ============================================================================
//  Module      : convert_signed_magnitude
//  Description : Two's complement <-> sign-magnitude converter with a fixed
//                start-to-done latency and registered, held results.
//  Revision    : 1.0 - initial release
// ============================================================================

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module convert_signed_magnitude #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic             sign_in,
    output logic [WIDTH-1:0] result,
    output logic             sign,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_last = 3'(LATENCY - 1);

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_cnt, w_cnt_nxt;
    logic             r_done, w_done_nxt;
    logic             w_load, w_commit;
    logic [WIDTH-1:0] r_a;
    logic             r_mode, r_sign_in;
    logic [WIDTH-1:0] r_result;
    logic             r_sign, r_ovf;

    logic [WIDTH-1:0] w_a_inv, w_neg, w_carry, w_res;
    logic             w_cout_unused, w_negate, w_sgn, w_ovf;

    // Negation: inverted operand plus one, carried in at bit 0.
    assign w_a_inv    = ~r_a;
    assign w_carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        if (i < WIDTH - 1) begin : g_mid
            full_adder u_fa (
                .a   (w_a_inv[i]),
                .b   (1'b0),
                .cin (w_carry[i]),
                .s   (w_neg[i]),
                .cout(w_carry[i+1])
            );
        end else begin : g_last
            full_adder u_fa (
                .a   (w_a_inv[i]),
                .b   (1'b0),
                .cin (w_carry[i]),
                .s   (w_neg[i]),
                .cout(w_cout_unused)
            );
        end
    end

    assign w_negate = r_mode ? r_sign_in : r_a[WIDTH-1];
    assign w_res    = w_negate ? w_neg : r_a;
    assign w_sgn    = r_mode ? w_res[WIDTH-1] : r_a[WIDTH-1];
    // A magnitude above 2^(WIDTH-1) cannot be negated; any MSB set cannot stay positive.
    assign w_ovf    = r_mode & (r_sign_in ? (r_a[WIDTH-1] & (|r_a[WIDTH-2:0]))
                                          : r_a[WIDTH-1]);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = r_done;
        w_load      = 1'b0;
        w_commit    = 1'b0;
        if (start) begin
            w_load      = 1'b1;
            w_cnt_nxt   = 3'd0;
            w_state_nxt = WAIT;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = IDLE;
                WAIT: begin
                    if (r_cnt < c_last) begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end else begin
                        w_commit    = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
                DONE: begin
                    w_done_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= 3'd0;
            r_done    <= 1'b0;
            r_a       <= '0;
            r_mode    <= 1'b0;
            r_sign_in <= 1'b0;
            r_result  <= '0;
            r_sign    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            if (w_load) begin
                r_a       <= a;
                r_mode    <= mode;
                r_sign_in <= sign_in;
            end
            if (w_commit) begin
                r_result <= w_res;
                r_sign   <= w_sgn;
                r_ovf    <= w_ovf;
            end
        end
    end

    assign result = r_result;
    assign sign   = r_sign;
    assign ovf    = r_ovf;
    assign busy   = (r_state == WAIT);
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_convert_signed_magnitude.sv
`default_nettype none
// ============================================================================
//  Module      : tb_convert_signed_magnitude
//  Description : Scoreboard bench for convert_signed_magnitude (8/2 and 16/1).
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_convert_signed_magnitude;

    localparam int W = 8;
    localparam int L = 2;

    logic         clk = 1'b0;
    logic         rst, start, mode, sign_in;
    logic [7:0]   a, result;
    logic         sign, ovf, busy, done;

    logic         s16_start, s16_mode, s16_sign_in;
    logic [15:0]  s16_a, s16_result;
    logic         s16_sign, s16_ovf, s16_busy, s16_done;

    convert_signed_magnitude #(.WIDTH(W), .LATENCY(L)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .sign_in(sign_in),
        .result(result), .sign(sign), .ovf(ovf), .busy(busy), .done(done)
    );

    convert_signed_magnitude #(.WIDTH(16), .LATENCY(1)) u_dut16 (
        .clk(clk), .rst(rst), .start(s16_start), .mode(s16_mode), .a(s16_a),
        .sign_in(s16_sign_in), .result(s16_result), .sign(s16_sign), .ovf(s16_ovf),
        .busy(s16_busy), .done(s16_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         start_edge;
        int         due;
        bit         aborted;
        logic [7:0] res;
        bit         sg;
        bit         ov;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    logic       rst_q;
    int         total = 0;
    int         bad = 0;
    bit         mon_en = 0;
    logic [7:0] held_res = 8'h00;
    bit         held_sg = 0;
    bit         held_ov = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Plain integer arithmetic on the signed value being represented.
    function automatic void ref_model(int w, bit md, longint av, bit si,
                                      output longint res, output bit sg, output bit ov);
        longint m, half, v;
        m    = longint'(1) << w;
        half = m >> 1;
        if (!md) begin
            v   = (av >= half) ? av - m : av;
            sg  = (v < 0);
            res = ((v < 0) ? -v : v) % m;
            ov  = 0;
        end else begin
            v   = si ? -av : av;
            res = ((v % m) + m) % m;
            sg  = (res >= half);
            ov  = (v < -half) || (v > half - 1);
        end
    endfunction

    // Any operation still pending at edge e never produces its done pulse.
    function automatic void abort(int e);
        for (int i = q.size() - 1; i >= 0; i--) begin
            exp_t t;
            t = q[i];
            if (!t.aborted && t.due >= e) begin
                t.aborted = 1;
                t.due     = e;
                q[i]      = t;
            end
        end
    endfunction

    task automatic issue(bit md, logic [7:0] av, bit si);
        longint r;
        bit     sg, ov;
        exp_t   e;
        @(posedge clk);
        #1;
        rst = 1; start = 1; mode = md; a = av; sign_in = si;
        ref_model(W, md, longint'(av), si, r, sg, ov);
        abort(cyc + 1);
        e.start_edge = cyc + 1;
        e.due        = cyc + 1 + L;
        e.aborted    = 0;
        e.res        = r[7:0];
        e.sg         = sg;
        e.ov         = ov;
        q.push_back(e);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rst = 1; start = 0;
            a = 8'($urandom); mode = 1'($urandom_range(0, 1)); sign_in = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic reset_pulse(bit with_start);
        @(posedge clk);
        #1;
        rst = 0; start = with_start; a = 8'($urandom);
        abort(cyc + 1);
        @(posedge clk);
        #1;
        rst = 1; start = 0;
    endtask

    task automatic run16(bit md, logic [15:0] av, bit si);
        longint r;
        bit     sg, ov;
        ref_model(16, md, longint'(av), si, r, sg, ov);
        @(posedge clk);
        #1;
        s16_start = 1; s16_mode = md; s16_a = av; s16_sign_in = si;
        @(posedge clk);
        #1;
        s16_start = 0; s16_a = 16'($urandom); s16_mode = ~md; s16_sign_in = ~si;
        check("w16_busy", s16_busy, 1);
        check("w16_done_early", s16_done, 0);
        @(posedge clk);
        #1;
        check("w16_done", s16_done, 1);
        check("w16_result", s16_result, r[15:0]);
        check("w16_sign", s16_sign, sg);
        check("w16_ovf", s16_ovf, ov);
        check("w16_busy_off", s16_busy, 0);
        @(posedge clk);
        #1;
        check("w16_done_width", s16_done, 0);
    endtask

    always @(negedge clk) begin : monitor
        bit exp_done;
        bit exp_busy;
        if (mon_en) begin
            exp_done = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_done = !q[0].aborted;
                if (exp_done) begin
                    held_res = q[0].res;
                    held_sg  = q[0].sg;
                    held_ov  = q[0].ov;
                end
                void'(q.pop_front());
            end
            if (!rst_q) begin
                held_res = 8'h00; held_sg = 0; held_ov = 0;
                check("rst_result", result, 0);
                check("rst_sign", sign, 0);
                check("rst_ovf", ovf, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
            end else begin
                exp_busy = (q.size() > 0) && (q[0].start_edge <= cyc) && (cyc < q[0].due);
                check("done", done, exp_done);
                check("busy", busy, exp_busy);
                check("result", result, held_res);
                check("sign", sign, held_sg);
                check("ovf", ovf, held_ov);
            end
        end
    end

    initial begin
        rst = 0; start = 0; mode = 0; a = 8'h00; sign_in = 0;
        s16_start = 0; s16_mode = 0; s16_a = 16'h0000; s16_sign_in = 0;
        @(posedge clk);
        #1;
        mon_en = 1;
        @(posedge clk);
        #1;
        idle(1);

        issue(0, 8'hF6, 0); idle(3);
        issue(0, 8'h80, 0); idle(3);
        issue(0, 8'h25, 0); idle(3);
        issue(1, 8'h0A, 1); idle(3);
        issue(1, 8'h81, 1); idle(3);
        issue(1, 8'h80, 0); idle(3);
        issue(1, 8'h00, 1); idle(3);
        issue(0, 8'hF6, 0); issue(0, 8'hFF, 0); idle(4);
        issue(0, 8'h9C, 0); idle(1); reset_pulse(0); idle(1);
        issue(0, 8'hF6, 0); idle(3);
        issue(1, 8'h33, 1); reset_pulse(1); idle(3);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) reset_pulse(1'($urandom_range(0, 1)));
            issue(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            idle(int'($urandom_range(0, 3)));
        end
        idle(5);
        check("drain", q.size(), 0);

        run16(0, 16'h8000, 0);
        run16(1, 16'h8000, 1);
        for (int i = 0; i < 10; i++) begin
            run16(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/convert_signed_magnitude.md
CONVERT_SIGNED_MAGNITUDE -- requirements
Module: convert_signed_magnitude

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal values >= 2).
REQ-002 SHALL have parameter: LATENCY, 2, cycles from a sampled start to done (legal values 1..7).
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port: start  input  1  request; samples the operands on the same edge.
REQ-006 SHALL have port: mode  input  1  0 = two's complement to sign-magnitude; 1 = sign-magnitude to two's complement.
REQ-007 SHALL have port: a  input  WIDTH  operand; two's complement value in mode 0, magnitude in mode 1.
REQ-008 SHALL have port: sign_in  input  1  operand sign (1 = negative); used in mode 1 only.
REQ-009 SHALL have port: result  output  WIDTH  registered result; magnitude in mode 0, two's complement value in mode 1.
REQ-010 SHALL have port: sign  output  1  registered result sign (1 = negative).
REQ-011 SHALL have port: ovf  output  1  registered flag; mode 1 value not representable in WIDTH bits.
REQ-012 SHALL have port: busy  output  1  high in WAIT state.
REQ-013 SHALL have port: done  output  1  one-cycle pulse; result, sign and ovf valid from this cycle.

Function
REQ-014 SHALL have the FSM states IDLE, WAIT and DONE, plus a 3-bit wait counter cnt.
REQ-015 SHALL, on an edge in any state with start=1: capture a, mode and sign_in into internal registers, set cnt=0, go to WAIT, and clear done.
REQ-016 SHALL, when start arrives in WAIT, restart the operation: discard the old operands and produce no done pulse for them.
REQ-017 SHALL, in WAIT with start=0: increment cnt when cnt < LATENCY-1; otherwise register result, sign and ovf, set done=1, and go to DONE.
REQ-018 SHALL therefore make done visible exactly LATENCY cycles after the start edge, with busy high for those cycles.
REQ-019 SHALL, in DONE with start=0: clear done and go to IDLE, so done is exactly one cycle wide.
REQ-020 SHALL hold result, sign and ovf unchanged from the done edge until the next done edge or reset; a new start SHALL NOT clear them.
REQ-021 SHALL ignore changes on a, mode and sign_in after the start edge.
REQ-022 SHALL, in mode 0, drive sign = a[WIDTH-1] and result = (~a + 1) mod 2^WIDTH when negative, otherwise a, with ovf = 0.
REQ-023 SHALL, in mode 0, produce the most-negative input 2^(WIDTH-1) as result = 2^(WIDTH-1) (unsigned magnitude), sign = 1, ovf = 0.
REQ-024 SHALL, in mode 1, drive result = (~a + 1) mod 2^WIDTH when sign_in = 1, otherwise a, and sign = result[WIDTH-1].
REQ-025 SHALL, in mode 1, set ovf = 1 when (sign_in = 1 and a > 2^(WIDTH-1)) or (sign_in = 0 and a[WIDTH-1] = 1); result still carries the wrapped value.
REQ-026 SHALL, in mode 1, treat negative zero (sign_in = 1, a = 0) as result = 0, sign = 0, ovf = 0.
REQ-027 SHALL implement the negation as a WIDTH-bit ripple of full_adder cells with carry-in 1 on the inverted operand; the final carry-out is unused.

Reset
REQ-028 SHALL, on an edge with rst = 0: go to IDLE, set cnt = 0, and clear result, sign, ovf, busy and done to 0.
REQ-029 SHALL give reset priority over start.
REQ-030 SHALL abort any operation in progress on reset, with no done pulse afterwards.

Verification (WIDTH=8, LATENCY=2 unless stated)
REQ-031 SHALL cover: mode 0, a=0xF6, start at edge k -> busy high after k and k+1; done=1 after k+2 only; result=0x0A, sign=1, ovf=0.
REQ-032 SHALL cover: mode 0, a=0x80 -> result=0x80, sign=1; a=0x25 -> result=0x25, sign=0; ovf=0 in both.
REQ-033 SHALL cover: mode 1 -> (sign_in=1, a=0x0A) gives 0xF6, sign 1, ovf 0; (1, 0x81) gives 0x7F, ovf 1; (0, 0x80) gives 0x80, ovf 1; (1, 0x00) gives 0x00, sign 0, ovf 0.
REQ-034 SHALL cover: start with a=0xF6, then start with a=0xFF one edge later -> exactly one done pulse, 2 cycles after the second start, result=0x01, sign=1.
REQ-035 SHALL cover: rst=0 for one edge during WAIT -> no done pulse; all outputs 0; next start completes normally.
REQ-036 SHALL cover: WIDTH=16, LATENCY=1, mode 0, a=0x8000 -> done 1 cycle after start; result=0x8000, sign=1, ovf=0.
